// File: rtl/wb_ext_data_bridge.sv
// wb_ext_data_bridge
//   Wishbone classic slave that forwards single accesses inside a fixed
//   address window to the ext_data port of the core as one request/rvalid
//   transaction. A response timeout returns ERR_DATA with an ack, so a stalled
//   core can never hang the Wishbone bus. Only one transaction is in flight.
//
// Ports
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   wbs_stb_i/cyc_i/we_i      Wishbone strobe, cycle, write enable
//   wbs_sel_i, wbs_adr_i      byte selects, byte address
//   wbs_dat_i / wbs_dat_o     write data / read data (0 outside the ack cycle)
//   wbs_ack_o                 one-cycle acknowledge
//   ext_data_addr_o/be_o/
//   wdata_o/we_o              latched request payload (window word offset)
//   ext_data_req_o            one-cycle request pulse
//   ext_data_rdata_i/rvalid_i response from the core (completes reads and writes)
//   err_count_o               saturating count of timeouts
module wb_ext_data_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [31:0] ADDR_MASK = 32'hFFFF_F000,
    parameter logic [7:0]  TIMEOUT   = 8'd64,
    parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [31:0] ext_data_addr_o,
    output logic [3:0]  ext_data_be_o,
    output logic [31:0] ext_data_wdata_o,
    output logic        ext_data_we_o,
    output logic        ext_data_req_o,
    input  logic [31:0] ext_data_rdata_i,
    input  logic        ext_data_rvalid_i,
    output logic [7:0]  err_count_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_ACK,
        S_DROP
    } state_t;

    state_t      state, state_next;
    logic [7:0]  cnt, cnt_next;
    logic        abort, abort_next;
    logic [7:0]  err_next;
    logic [31:0] dat_next;
    logic [31:0] addr_next;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic        we_next;
    logic        hit;
    logic        finish;
    logic        tmo;
    logic        abort_now;

    assign hit = wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        abort_next = abort;
        err_next   = err_count_o;
        dat_next   = '0;
        addr_next  = ext_data_addr_o;
        be_next    = ext_data_be_o;
        wdata_next = ext_data_wdata_o;
        we_next    = ext_data_we_o;
        finish     = 1'b0;
        tmo        = 1'b0;
        // A cycle dropped at any point of the transaction turns the ack into a drop.
        abort_now  = abort | ~wbs_cyc_i;

        case (state)
            S_IDLE: begin
                if (hit) begin
                    addr_next  = wbs_adr_i & ~ADDR_MASK & 32'hFFFF_FFFC;
                    be_next    = wbs_sel_i;
                    wdata_next = wbs_dat_i;
                    we_next    = wbs_we_i;
                    abort_next = 1'b0;
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                abort_next = abort_now;
                if (ext_data_rvalid_i) begin
                    finish = 1'b1;
                end else begin
                    cnt_next   = '0;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                abort_next = abort_now;
                // cnt holds the number of WAIT cycles already completed, so the
                // timeout fires at the end of WAIT cycle number TIMEOUT.
                if (ext_data_rvalid_i) begin
                    finish = 1'b1;
                end else if (cnt == TIMEOUT - 8'd1) begin
                    finish = 1'b1;
                    tmo    = 1'b1;
                    if (err_count_o != 8'hFF) err_next = err_count_o + 8'd1;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            S_ACK:   state_next = S_IDLE;
            S_DROP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase

        if (finish) begin
            state_next = abort_now ? S_DROP : S_ACK;
            if (!abort_now && !ext_data_we_o)
                dat_next = tmo ? ERR_DATA : ext_data_rdata_i;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state            <= S_IDLE;
            cnt              <= '0;
            abort            <= 1'b0;
            err_count_o      <= '0;
            wbs_ack_o        <= 1'b0;
            wbs_dat_o        <= '0;
            ext_data_req_o   <= 1'b0;
            ext_data_addr_o  <= '0;
            ext_data_be_o    <= '0;
            ext_data_wdata_o <= '0;
            ext_data_we_o    <= 1'b0;
        end else begin
            state            <= state_next;
            cnt              <= cnt_next;
            abort            <= abort_next;
            err_count_o      <= err_next;
            wbs_ack_o        <= (state_next == S_ACK);
            wbs_dat_o        <= dat_next;
            ext_data_req_o   <= (state_next == S_REQ);
            ext_data_addr_o  <= addr_next;
            ext_data_be_o    <= be_next;
            ext_data_wdata_o <= wdata_next;
            ext_data_we_o    <= we_next;
        end
    end

endmodule

// File: tb/tb_wb_ext_data_bridge.sv
// Directed bench for wb_ext_data_bridge: inputs change on the falling edge,
// outputs are observed on the falling edge, one cycle per negedge.
module tb_wb_ext_data_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack;
    logic [31:0] rdat;
    logic [31:0] x_addr;
    logic [3:0]  x_be;
    logic [31:0] x_wdata;
    logic        x_we;
    logic        x_req;
    logic [31:0] x_rdata;
    logic        x_rvalid;
    logic [7:0]  err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_ext_data_bridge dut (
        .wb_clk_i         (clk),
        .wb_rst_i         (rst),
        .wbs_stb_i        (stb),
        .wbs_cyc_i        (cyc),
        .wbs_we_i         (we),
        .wbs_sel_i        (sel),
        .wbs_adr_i        (adr),
        .wbs_dat_i        (wdat),
        .wbs_ack_o        (ack),
        .wbs_dat_o        (rdat),
        .ext_data_addr_o  (x_addr),
        .ext_data_be_o    (x_be),
        .ext_data_wdata_o (x_wdata),
        .ext_data_we_o    (x_we),
        .ext_data_req_o   (x_req),
        .ext_data_rdata_i (x_rdata),
        .ext_data_rvalid_i(x_rvalid),
        .err_count_o      (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    endtask

    task automatic idle_bus();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    // Counts negedges after the hit until ack is seen; 0 if it never comes.
    task automatic wait_ack(input int maxc, output int lat);
        lat = 0;
        for (int i = 1; i <= maxc; i++) begin
            @(negedge clk);
            if (ack === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"},   ack,     0);
        check({tag, "_req"},   x_req,   0);
        check({tag, "_we"},    x_we,    0);
        check({tag, "_dat"},   rdat,    0);
        check({tag, "_addr"},  x_addr,  0);
        check({tag, "_wdata"}, x_wdata, 0);
        check({tag, "_be"},    x_be,    0);
        check({tag, "_err"},   err,     0);
    endtask

    initial begin
        int lat;
        int nack;
        int nreq;
        bit got;

        rst = 1'b1; stb = 0; cyc = 0; we = 0; sel = 0; adr = 0; wdat = 0;
        x_rdata = 0; x_rvalid = 0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Write, slave answers one cycle after req: ack 3 cycles after the hit.
        start(1'b1, 32'h3000_0010, 32'hA5A5_1234, 4'b0011);
        @(negedge clk);                       // n+1
        check("wr_req",   x_req,   1);
        check("wr_addr",  x_addr,  32'h10);
        check("wr_be",    x_be,    4'b0011);
        check("wr_we",    x_we,    1);
        check("wr_wdata", x_wdata, 32'hA5A5_1234);
        @(negedge clk);                       // n+2
        check("wr_req_pulse", x_req, 0);
        check("wr_ack_early", ack,   0);
        x_rvalid = 1'b1; x_rdata = 32'h1111_2222;
        @(negedge clk);                       // n+3
        check("wr_ack", ack,  1);
        check("wr_dat", rdat, 0);
        x_rvalid = 1'b0; idle_bus();
        @(negedge clk);
        check("wr_ack_pulse", ack, 0);

        // Read at the top word, data after 3 cycles.
        start(1'b0, 32'h3000_0FFC, 32'h0, 4'hF);
        @(negedge clk);                       // n+1
        check("rd_req",  x_req,  1);
        check("rd_addr", x_addr, 32'hFFC);
        check("rd_we",   x_we,   0);
        @(negedge clk);                       // n+2
        @(negedge clk);                       // n+3
        check("rd_ack_early", ack,  0);
        check("rd_dat_early", rdat, 0);
        @(negedge clk);                       // n+4
        x_rvalid = 1'b1; x_rdata = 32'hCAFE_F00D;
        @(negedge clk);                       // n+5
        check("rd_ack", ack,  1);
        check("rd_dat", rdat, 32'hCAFE_F00D);
        x_rvalid = 1'b0; x_rdata = 32'h0; idle_bus();
        @(negedge clk);
        check("rd_ack_pulse", ack,  0);
        check("rd_dat_after", rdat, 0);

        // Timeout on a read.
        check("tmo_err_before", err, 0);
        start(1'b0, 32'h3000_0020, 32'h0, 4'hF);
        wait_ack(200, lat);
        check("tmo_latency", lat,  66);
        check("tmo_dat",     rdat, 32'hDEAD_BEEF);
        check("tmo_err",     err,  1);
        idle_bus();
        @(negedge clk);
        for (int r = 1; r < 300; r++) begin
            start(1'b0, 32'h3000_0020, 32'h0, 4'hF);
            wait_ack(200, lat);
            idle_bus();
            @(negedge clk);
            if (r == 254) check("tmo_err_255", err, 255);
        end
        check("tmo_err_sat", err, 255);

        // Outside the window: nothing happens.
        start(1'b0, 32'h3000_1000, 32'h0, 4'hF);
        nack = 0; nreq = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ack)   nack++;
            if (x_req) nreq++;
        end
        check("miss_acks", nack, 0);
        check("miss_reqs", nreq, 0);
        idle_bus();
        @(negedge clk);

        // Abort: cyc falls one cycle after req, rvalid five cycles later.
        start(1'b0, 32'h3000_0040, 32'h0, 4'hF);
        @(negedge clk);                       // n+1
        check("abort_req", x_req, 1);
        nack = 0;
        for (int i = 2; i <= 8; i++) begin
            @(negedge clk);                   // n+i
            if (ack) nack++;
            if (i == 2) idle_bus();
            x_rvalid = (i == 7);
            x_rdata  = (i == 7) ? 32'h1234_5678 : 32'h0;
        end
        @(negedge clk);                       // n+9: two cycles after rvalid
        if (ack) nack++;
        check("abort_no_ack", nack, 0);
        start(1'b1, 32'h3000_0080, 32'h0BAD_F00D, 4'hF);
        @(negedge clk);
        check("post_abort_req",  x_req,  1);
        check("post_abort_addr", x_addr, 32'h80);
        x_rvalid = 1'b1;
        @(negedge clk);
        check("post_abort_ack", ack,  1);
        check("post_abort_dat", rdat, 0);
        x_rvalid = 1'b0; idle_bus();
        @(negedge clk);

        // Reset while waiting; the late rvalid must be ignored.
        start(1'b0, 32'h3000_0100, 32'h0, 4'hF);
        @(negedge clk);                       // n+1 REQ
        @(negedge clk);                       // n+2 WAIT
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0; idle_bus();
        nack = 0; nreq = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack)   nack++;
            if (x_req) nreq++;
            x_rvalid = (i == 0);
            x_rdata  = 32'h7777_7777;
        end
        check("midrst_no_ack", nack, 0);
        check("midrst_no_req", nreq, 0);
        check("midrst_err",    err,  0);

        // rvalid in the same cycle the timeout would fire: data wins, no error.
        start(1'b0, 32'h3000_0200, 32'h0, 4'hF);
        got = 0; lat = 0;
        for (int i = 1; i <= 80 && !got; i++) begin
            @(negedge clk);
            if (ack) begin got = 1; lat = i; end
            x_rvalid = (i == 65);
            x_rdata  = 32'h55AA_55AA;
        end
        check("tie_latency", lat,  66);
        check("tie_dat",     rdat, 32'h55AA_55AA);
        check("tie_err",     err,  0);
        x_rvalid = 1'b0; idle_bus();
        @(negedge clk);

        // Write timeout: error counted, data stays 0.
        start(1'b1, 32'h3000_0300, 32'hFFFF_0000, 4'b1100);
        wait_ack(200, lat);
        check("wtmo_latency", lat,  66);
        check("wtmo_dat",     rdat, 0);
        check("wtmo_err",     err,  1);
        idle_bus();
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
